// File: rtl/led_pattern_pkg.sv
// rtl/led_pattern_pkg.sv - shared mode and phase encodings for the LED pattern generator
package led_pattern_pkg;

  typedef enum logic [1:0] {
    MODE_FILL_L = 2'd0,
    MODE_FILL_R = 2'd1,
    MODE_BOUNCE = 2'd2,
    MODE_CENTER = 2'd3
  } mode_e;

  typedef enum logic {
    PH_FILL  = 1'b0,
    PH_DRAIN = 1'b1
  } phase_e;

  // BOUNCE reuses the fill/drain phase bit as its travel direction
  localparam phase_e PH_UP   = PH_FILL;
  localparam phase_e PH_DOWN = PH_DRAIN;

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - enabled step-rate divider, one tick every div+1 enabled cycles
module tick_prescaler #(
  parameter int DIV_W = 24
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [DIV_W-1:0] i_div,
  output logic             o_tick
);

  logic [DIV_W-1:0] r_cnt;
  logic             w_hit;

  // >= rather than == so a divisor shrunk below the count fires on the next enabled cycle
  assign w_hit  = (r_cnt >= i_div);
  assign o_tick = i_en & w_hit;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_hit ? '0 : r_cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/led_pattern_gen.sv
// rtl/led_pattern_gen.sv - parametrised LED pattern generator with prescaler, four patterns and step/wrap pulses
module led_pattern_gen
  import led_pattern_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIV_W = 24
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic [1:0]       i_mode,
  input  logic [DIV_W-1:0] i_div,
  output logic [WIDTH-1:0] o_out,
  output logic             o_step,
  output logic             o_wrap
);

  localparam int H = WIDTH / 2;
  localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);
  localparam logic [WIDTH-1:0] ALL_ONES   = '1;
  localparam logic [WIDTH-1:0] MSB        = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] LOWER_MASK = {{H{1'b0}}, {H{1'b1}}};
  localparam logic [WIDTH-1:0] UPPER_MASK = ~LOWER_MASK;
  localparam logic [WIDTH-1:0] CENTER_PAIR = WIDTH'(2'b11) << (H - 1);

  logic [WIDTH-1:0] r_out;
  phase_e           r_phase;
  mode_e            r_mode_q;
  logic             r_step;
  logic             r_wrap;

  logic             w_restart;
  logic             w_tick;
  logic             w_onehot;
  logic [WIDTH-1:0] w_upper;
  logic [WIDTH-1:0] w_lower;
  logic [WIDTH-1:0] w_out_nxt;
  phase_e           w_phase_nxt;
  logic             w_wrap_nxt;

  assign w_restart = (mode_e'(i_mode) != r_mode_q);
  assign w_onehot  = (r_out != '0) && ((r_out & (r_out - ONE)) == '0);
  assign w_upper   = r_out & UPPER_MASK;
  assign w_lower   = r_out & LOWER_MASK;

  // A mode restart also clears the prescaler so the new pattern gets a full first step
  tick_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .i_clk  (i_clk),
    .i_rst  (i_rst | w_restart),
    .i_en   (i_en),
    .i_div  (i_div),
    .o_tick (w_tick)
  );

  always_comb begin
    w_out_nxt   = r_out;
    w_phase_nxt = r_phase;
    w_wrap_nxt  = 1'b0;
    case (r_mode_q)
      MODE_FILL_L: begin
        if (r_phase == PH_FILL) begin
          if (r_out == ALL_ONES) w_phase_nxt = PH_DRAIN;
          else                   w_out_nxt   = (r_out << 1) | ONE;
        end else begin
          if (r_out == '0) begin
            w_phase_nxt = PH_FILL;
            w_wrap_nxt  = 1'b1;
          end else begin
            w_out_nxt = r_out << 1;
          end
        end
      end
      MODE_FILL_R: begin
        if (r_phase == PH_FILL) begin
          if (r_out == ALL_ONES) w_phase_nxt = PH_DRAIN;
          else                   w_out_nxt   = (r_out >> 1) | MSB;
        end else begin
          if (r_out == '0) begin
            w_phase_nxt = PH_FILL;
            w_wrap_nxt  = 1'b1;
          end else begin
            w_out_nxt = r_out >> 1;
          end
        end
      end
      MODE_BOUNCE: begin
        if (!w_onehot) begin
          w_out_nxt   = ONE;
          w_phase_nxt = PH_UP;
        end else if (r_phase == PH_UP && !r_out[WIDTH-1]) begin
          w_out_nxt = r_out << 1;
        end else if (r_phase == PH_UP || !r_out[0]) begin
          // Reversal at the top edge costs no extra step
          w_out_nxt   = r_out >> 1;
          w_phase_nxt = w_out_nxt[0] ? PH_UP : PH_DOWN;
          w_wrap_nxt  = w_out_nxt[0];
        end else begin
          w_out_nxt   = r_out << 1;
          w_phase_nxt = PH_UP;
        end
      end
      MODE_CENTER: begin
        if (r_phase == PH_FILL) begin
          if (r_out == ALL_ONES) w_phase_nxt = PH_DRAIN;
          else                   w_out_nxt   = r_out | (r_out << 1) | (r_out >> 1) | CENTER_PAIR;
        end else begin
          if (r_out == '0) begin
            w_phase_nxt = PH_FILL;
            w_wrap_nxt  = 1'b1;
          end else begin
            // Each half loses its bit nearest the centre
            w_out_nxt = (w_upper & (w_upper << 1)) | (w_lower & (w_lower >> 1));
          end
        end
      end
      default: begin
        w_out_nxt = r_out;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_out    <= '0;
      r_phase  <= PH_FILL;
      r_mode_q <= MODE_FILL_L;
      r_step   <= 1'b0;
      r_wrap   <= 1'b0;
    end else if (w_restart) begin
      r_mode_q <= mode_e'(i_mode);
      r_out    <= (mode_e'(i_mode) == MODE_BOUNCE) ? ONE : '0;
      r_phase  <= PH_FILL;
      r_step   <= 1'b0;
      r_wrap   <= 1'b0;
    end else if (w_tick) begin
      r_out    <= w_out_nxt;
      r_phase  <= w_phase_nxt;
      r_step   <= 1'b1;
      r_wrap   <= w_wrap_nxt;
    end else begin
      r_step   <= 1'b0;
      r_wrap   <= 1'b0;
    end
  end

  assign o_out  = r_out;
  assign o_step = r_step;
  assign o_wrap = r_wrap;

endmodule

// File: tb/tb_led_pattern_gen.sv
// tb/tb_led_pattern_gen.sv - table-driven scoreboard bench for led_pattern_gen at WIDTH=8
module tb_led_pattern_gen;

  typedef struct {
    logic        rst;
    logic        en;
    logic [1:0]  mode;
    logic [23:0] div;
    logic [7:0]  exp_out;
    logic        exp_step;
    logic        exp_wrap;
  } vec_t;

  typedef struct {
    logic [7:0] out;
    logic       step;
    logic       wrap;
    string      tag;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        en;
  logic [1:0]  mode;
  logic [23:0] div;
  logic [7:0]  out;
  logic        step;
  logic        wrap;

  int   n_tests;
  int   n_fail;
  vec_t tbl[$];
  exp_t sb[$];

  led_pattern_gen #(
    .WIDTH (8),
    .DIV_W (24)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_en   (en),
    .i_mode (mode),
    .i_div  (div),
    .o_out  (out),
    .o_step (step),
    .o_wrap (wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(logic r, logic e, logic [1:0] m, logic [23:0] d,
                              logic [7:0] o, logic s, logic w);
    vec_t v;
    v.rst = r; v.en = e; v.mode = m; v.div = d;
    v.exp_out = o; v.exp_step = s; v.exp_wrap = w;
    tbl.push_back(v);
  endfunction

  task automatic check(string name, logic [7:0] act, logic [7:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Drive one cycle, queue its expectation, then pop and compare after the edge
  task automatic cyc(logic r, logic e, logic [1:0] m, logic [23:0] d,
                     logic [7:0] o, logic s, logic w, string tag);
    exp_t x;
    exp_t y;
    rst = r; en = e; mode = m; div = d;
    x.out = o; x.step = s; x.wrap = w; x.tag = tag;
    sb.push_back(x);
    @(posedge clk);
    #1;
    y = sb.pop_front();
    check({y.tag, ".out"},  out,         y.out);
    check({y.tag, ".step"}, {7'd0, step}, {7'd0, y.step});
    check({y.tag, ".wrap"}, {7'd0, wrap}, {7'd0, y.wrap});
  endtask

  initial begin
    logic [7:0] seq_fl[19] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'hFF, 8'hFE,
                               8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00, 8'h00, 8'h01};
    logic [7:0] seq_bo[15] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40,
                               8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
    logic [7:0] seq_ce[11] = '{8'h18, 8'h3C, 8'h7E, 8'hFF, 8'hFF, 8'hE7, 8'hC3, 8'h81, 8'h00, 8'h00, 8'h18};
    logic [7:0] seq_fr[19] = '{8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF, 8'hFF, 8'h7F,
                               8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00, 8'h00, 8'h80};
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1; en = 1'b0; mode = 2'd0; div = '0;

    add(1'b1, 1'b0, 2'd0, 24'd0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 19; i++) add(1'b0, 1'b1, 2'd0, 24'd0, seq_fl[i], 1'b1, (i == 17));
    add(1'b0, 1'b1, 2'd2, 24'd0, 8'h01, 1'b0, 1'b0);
    for (int i = 0; i < 15; i++) add(1'b0, 1'b1, 2'd2, 24'd0, seq_bo[i], 1'b1, (i == 13));
    add(1'b0, 1'b1, 2'd3, 24'd0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 11; i++) add(1'b0, 1'b1, 2'd3, 24'd0, seq_ce[i], 1'b1, (i == 9));
    add(1'b0, 1'b1, 2'd1, 24'd0, 8'h00, 1'b0, 1'b0);
    for (int i = 0; i < 19; i++) add(1'b0, 1'b1, 2'd1, 24'd0, seq_fr[i], 1'b1, (i == 17));

    @(negedge clk);
    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i].rst, tbl[i].en, tbl[i].mode, tbl[i].div,
          tbl[i].exp_out, tbl[i].exp_step, tbl[i].exp_wrap, $sformatf("tbl%0d", i));
    end

    // Prescaler div=3 with a 5-cycle enable gap mid-count
    cyc(1'b1, 1'b0, 2'd0, 24'd3, 8'h00, 1'b0, 1'b0, "pre_rst");
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 2'd0, 24'd3, 8'h00, 1'b0, 1'b0, $sformatf("pre_a%0d", i));
    cyc(1'b0, 1'b1, 2'd0, 24'd3, 8'h01, 1'b1, 1'b0, "pre_tick1");
    for (int i = 0; i < 2; i++) cyc(1'b0, 1'b1, 2'd0, 24'd3, 8'h01, 1'b0, 1'b0, $sformatf("pre_b%0d", i));
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 2'd0, 24'd3, 8'h01, 1'b0, 1'b0, $sformatf("pre_off%0d", i));
    cyc(1'b0, 1'b1, 2'd0, 24'd3, 8'h01, 1'b0, 1'b0, "pre_c0");
    cyc(1'b0, 1'b1, 2'd0, 24'd3, 8'h03, 1'b1, 1'b0, "pre_tick2");
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 2'd0, 24'd3, 8'h03, 1'b0, 1'b0, $sformatf("pre_d%0d", i));
    cyc(1'b0, 1'b1, 2'd0, 24'd3, 8'h07, 1'b1, 1'b0, "pre_tick3");

    // Mode switch 0->2 coinciding with a tick at out=3F
    cyc(1'b1, 1'b0, 2'd0, 24'd0, 8'h00, 1'b0, 1'b0, "sw_rst");
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b1, 2'd0, 24'd0, seq_fl[i], 1'b1, 1'b0, $sformatf("sw_fill%0d", i));
    cyc(1'b0, 1'b1, 2'd2, 24'd0, 8'h01, 1'b0, 1'b0, "sw_restart");
    cyc(1'b0, 1'b1, 2'd2, 24'd1, 8'h01, 1'b0, 1'b0, "sw_cnt0");
    cyc(1'b0, 1'b1, 2'd2, 24'd1, 8'h02, 1'b1, 1'b0, "sw_up");

    // Restart still happens with en=0, then holds
    cyc(1'b0, 1'b0, 2'd3, 24'd0, 8'h00, 1'b0, 1'b0, "off_restart");
    cyc(1'b0, 1'b0, 2'd3, 24'd0, 8'h00, 1'b0, 1'b0, "off_hold");

    // Reset during CENTER drain at C3, then restart and delayed refill
    cyc(1'b1, 1'b0, 2'd0, 24'd0, 8'h00, 1'b0, 1'b0, "cr_rst0");
    cyc(1'b0, 1'b1, 2'd3, 24'd0, 8'h00, 1'b0, 1'b0, "cr_restart0");
    for (int i = 0; i < 7; i++) cyc(1'b0, 1'b1, 2'd3, 24'd0, seq_ce[i], 1'b1, 1'b0, $sformatf("cr_run%0d", i));
    cyc(1'b1, 1'b1, 2'd3, 24'd0, 8'h00, 1'b0, 1'b0, "cr_rst");
    cyc(1'b0, 1'b1, 2'd3, 24'd1, 8'h00, 1'b0, 1'b0, "cr_restart");
    cyc(1'b0, 1'b1, 2'd3, 24'd1, 8'h00, 1'b0, 1'b0, "cr_wait");
    cyc(1'b0, 1'b1, 2'd3, 24'd1, 8'h18, 1'b1, 1'b0, "cr_fill");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
